// File: rtl/mux_rr_n_if.sv
// Handshake bundle between N producer channels, the mux and its single consumer.
// The master is the surrounding logic; the slave is the mux itself.
interface mux_rr_n_if #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int SW = 2
);
  logic            mode;
  logic [SW-1:0]   sel;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [W-1:0]    out_data;
  logic [SW-1:0]   out_ch;
  logic            out_valid;
  logic            out_ready;

  modport master (
    output mode, sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_ch, out_valid
  );

  modport slave (
    input  mode, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_ch, out_valid
  );
endinterface

// File: rtl/mux_rr_n.sv
// N:1 registered mux, fixed-select or round-robin; one cycle input-to-output latency.
// Single output register, no skid: in_ready is zero while the held word is stalled.
module mux_rr_n #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int SW = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  mux_rr_n_if.slave  bus
);

  logic [SW-1:0] ptr;
  logic [SW-1:0] grant;
  logic          grant_valid;
  logic          load;
  int            idx;

  assign load = ~bus.out_valid | bus.out_ready;

  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    idx         = 0;
    if (!bus.mode) begin
      for (int k = 0; k < N; k++) begin
        if (bus.sel == SW'(k) && bus.in_valid[k]) begin
          grant_valid = 1'b1;
          grant       = SW'(k);
        end
      end
    end else begin
      // Walk from the far end back toward ptr so the closest valid channel wins.
      for (int i = N - 1; i >= 0; i--) begin
        idx = (int'(ptr) + i) % N;
        if (bus.in_valid[idx]) begin
          grant_valid = 1'b1;
          grant       = SW'(idx);
        end
      end
    end
  end

  assign bus.in_ready = (rst_n && load && grant_valid) ? (N'(1) << grant) : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.out_data  <= '0;
      bus.out_ch    <= '0;
      bus.out_valid <= 1'b0;
      ptr           <= '0;
    end else if (load && grant_valid) begin
      bus.out_data  <= bus.in_data[int'(grant)*W +: W];
      bus.out_ch    <= grant;
      bus.out_valid <= 1'b1;
      if (bus.mode) begin
        ptr <= (grant == SW'(N - 1)) ? '0 : grant + SW'(1);
      end
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule
